// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: types and helpers shared by the ALU arbiter slice.
//   opcode_e  : 2-bit ALU opcode (ADD, SUB, MULT, NAND)
//   ST_*      : FSM state encodings for alu_arbiter
//   id_w()    : requester-id width, max(1, clog2(n))
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_MULT = 2'd2,
      OP_NAND = 2'd3
   } opcode_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the clients and alu_arbiter.
//   req_valid/req_ready : per-requester handshake, ready is one-hot or zero
//   req_opcode/op1/op2  : packed per-requester operands (requester i at slot i)
//   rsp_valid/rsp_ready : single response handshake
//   rsp_data/rsp_id     : result and index of the requester that issued it
//   busy                : arbiter is not idle
// master = client side, slave = arbiter side.
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*2-1:0]     req_opcode;
   logic [NUM_REQ*WIDTH-1:0] req_op1;
   logic [NUM_REQ*WIDTH-1:0] req_op2;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [WIDTH-1:0]         rsp_data;
   logic [ID_W-1:0]          rsp_id;
   logic                     busy;

   modport master (
      output req_valid, req_opcode, req_op1, req_op2, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_opcode, req_op1, req_op2, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational WIDTH-bit ALU. All results wrap modulo 2^WIDTH.
//   op   : opcode (ADD, SUB, MULT low half, NAND)
//   a, b : operands
//   y    : result
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  opcode_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_MULT: y = a * b;
         OP_NAND: y = ~(a & b);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester
//   any   : at least one request present
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   always_comb begin
      int k;
      k     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // Scan starting at ptr and wrapping; the first hit wins.
      for (int i = 0; i < NUM_REQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = ID_W'(k);
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ requesters, round-robin.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_arbiter_if (requests in, tagged result out)
// A grant is given only in IDLE; the winner's operands are latched and the ALU
// runs from those registers (MULT held for MULT_CYCLES). The result is held on
// the response channel until accepted, then the arbiter returns to IDLE.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_REQ     = 4,
   parameter int MULT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   alu_arbiter_if.slave bus
);
   localparam int ID_W  = id_w(NUM_REQ);
   localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   opcode_e          opc_q, opc_d;
   logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

   logic [NUM_REQ-1:0] gnt_oh, req_ready;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [31:0]        gsel;
   logic [WIDTH-1:0]   alu_y;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (gnt_oh),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   // Fed only from latched registers so clients may change inputs after accept.
   alu #(.WIDTH(WIDTH)) u_alu (
      .op (opc_q),
      .a  (op1_q),
      .b  (op2_q),
      .y  (alu_y)
   );

   assign gsel = 32'(gnt_idx);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opc_d       = opc_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      id_d        = id_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      req_ready   = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               req_ready = gnt_oh;
               opc_d     = opcode_e'(bus.req_opcode[2*gsel +: 2]);
               op1_d     = bus.req_op1[WIDTH*gsel +: WIDTH];
               op2_d     = bus.req_op2[WIDTH*gsel +: WIDTH];
               id_d      = gnt_idx;
               rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
               cnt_d     = (opc_d == OP_MULT) ? CNT_W'(MULT_CYCLES-1) : '0;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = alu_y;
               rsp_id_d    = id_q;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            // No grant here even if requests wait: IDLE follows the handshake.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         opc_q       <= OP_ADD;
         op1_q       <= '0;
         op2_q       <= '0;
         id_q        <= '0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opc_q       <= opc_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         id_q        <= id_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter (WIDTH=32, NUM_REQ=4, MULT_CYCLES=2).
// Each requester owns a queue of pending operations; a grant predicted by the
// round-robin model pushes the expected tagged result and its due cycle, and the
// negedge monitor compares handshakes, busy and every response against it.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int WIDTH       = 32;
   localparam int NUM_REQ     = 4;
   localparam int MULT_CYCLES = 2;
   localparam int ID_W        = id_w(NUM_REQ);

   typedef struct {
      logic [1:0]       opc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
      int               due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MULT_CYCLES(MULT_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   req_t               rq [NUM_REQ][$];
   exp_t               sb [$];
   int                 rsp_log [$];
   int                 checks = 0;
   int                 errors = 0;
   int                 cyc = 0;
   int                 ptr = 0;
   int                 rdy_mode = 0;
   logic [NUM_REQ-1:0] acc_mask = '0;
   logic [WIDTH-1:0]   last_data = '0;
   int                 last_id = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Spec arithmetic, done wide then reduced modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] ref_alu(input req_t r);
      longint unsigned a, b, m, y;
      a = 64'(r.a);
      b = 64'(r.b);
      m = (64'd1 << WIDTH) - 64'd1;
      case (r.opc)
         2'd0:    y = a + b;
         2'd1:    y = a - b;
         2'd2:    y = a * b;
         default: y = ~(a & b);
      endcase
      return WIDTH'(y & m);
   endfunction

   // Request-side then response-side checking, in that order, every negedge.
   initial begin : mon
      int g, k;
      logic [NUM_REQ-1:0] exp_rdy;
      req_t r;
      exp_t e;
      forever begin
         @(negedge clk);
         acc_mask = '0;
         if (rst) begin
            sb.delete();
            ptr = 0;
         end else begin
            g = -1;
            if (sb.size() == 0) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  k = (ptr + i) % NUM_REQ;
                  if (g < 0 && bus.req_valid[k]) g = k;
               end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("busy", 64'(bus.busy), 64'(sb.size() != 0));
            if (g >= 0) begin
               r = rq[g][0];
               e.id   = g;
               e.data = ref_alu(r);
               e.due  = cyc + ((r.opc == 2'd2) ? 1 + MULT_CYCLES : 2);
               sb.push_back(e);
               ptr = (g + 1) % NUM_REQ;
               acc_mask[g] = 1'b1;
            end
            if (sb.size() != 0) begin
               e = sb[0];
               chk("rsp_valid", 64'(bus.rsp_valid), 64'(cyc >= e.due));
               if (bus.rsp_valid) begin
                  chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                  chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                  if (bus.rsp_ready) begin
                     void'(sb.pop_front());
                     rsp_log.push_back(e.id);
                     last_data = bus.rsp_data;
                     last_id   = int'(bus.rsp_id);
                  end
               end
            end else begin
               chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
         if (acc_mask[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_valid[i] = (rq[i].size() != 0);
         if (rq[i].size() != 0) begin
            bus.req_opcode[2*i +: 2]     = rq[i][0].opc;
            bus.req_op1[WIDTH*i +: WIDTH] = rq[i][0].a;
            bus.req_op2[WIDTH*i +: WIDTH] = rq[i][0].b;
         end else begin
            bus.req_opcode[2*i +: 2]     = 2'($urandom_range(0, 3));
            bus.req_op1[WIDTH*i +: WIDTH] = $urandom();
            bus.req_op2[WIDTH*i +: WIDTH] = $urandom();
         end
      end
      case (rdy_mode)
         0:       bus.rsp_ready = 1'b0;
         1:       bus.rsp_ready = 1'b1;
         default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push(input int i, input logic [1:0] opc, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
      req_t r;
      r.opc = opc;
      r.a   = a;
      r.b   = b;
      rq[i].push_back(r);
   endtask

   function automatic bit pending();
      bit p;
      p = (sb.size() != 0);
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         step();
         n++;
      end
      chk(nm, 64'(pending()), 64'd0);
      step();
   endtask

   initial begin : stim
      int exp_ids [5];
      int n, cnt2, base;
      exp_ids = '{0, 1, 2, 3, 0};
      bus.req_valid  = '0;
      bus.req_opcode = '0;
      bus.req_op1    = '0;
      bus.req_op2    = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      rst = 1'b0;

      // All requesters valid from reset, rsp_ready high.
      rdy_mode = 1;
      push(0, 2'd0, 32'd1, 32'd1);
      push(1, 2'd0, 32'd2, 32'd2);
      push(2, 2'd0, 32'd3, 32'd3);
      push(3, 2'd0, 32'd4, 32'd4);
      push(0, 2'd0, 32'd5, 32'd5);
      rsp_log.delete();
      drain("all_valid_drain", 100);
      chk("all_valid_count", 64'(rsp_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < rsp_log.size(); i++)
         chk($sformatf("rr_order_%0d", i), 64'(rsp_log[i]), 64'(exp_ids[i]));

      push(1, 2'd0, 32'd5, 32'd7);
      drain("add_drain", 50);
      chk("add_5_7", 64'(last_data), 64'd12);
      chk("add_id", 64'(last_id), 64'd1);

      push(0, 2'd2, 32'h0001_0000, 32'h0001_0000);
      drain("mult_drain", 50);
      chk("mult_trunc", 64'(last_data), 64'd0);

      push(3, 2'd1, 32'd3, 32'd5);
      drain("sub_drain", 50);
      chk("sub_borrow", 64'(last_data), 64'hFFFF_FFFE);

      push(1, 2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
      drain("nand_drain", 50);
      chk("nand", 64'(last_data), 64'h0FFF_0FFF);

      // Backpressure with requester 2 appearing then withdrawing while busy.
      rdy_mode = 0;
      push(0, 2'd0, 32'd9, 32'd9);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
      base = rsp_log.size();
      push(2, 2'd0, 32'd1, 32'd1);
      repeat (10) step();
      rq[2].delete();
      rdy_mode = 1;
      drain("bp_drain", 50);
      chk("bp_data", 64'(last_data), 64'd18);
      cnt2 = 0;
      for (int i = base; i < rsp_log.size(); i++) if (rsp_log[i] == 2) cnt2++;
      chk("drop_req2_no_rsp", 64'(cnt2), 64'd0);

      // Reset while a MULT is executing.
      push(0, 2'd2, 32'd3, 32'd4);
      n = 0;
      while (!bus.busy && n < 20) begin
         step();
         n++;
      end
      chk("mid_busy", 64'(bus.busy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
      step();
      step();
      rst = 1'b0;
      push(2, 2'd0, 32'h7FFF_FFFF, 32'd1);
      drain("post_rst_drain", 50);
      chk("post_rst_data", 64'(last_data), 64'h8000_0000);
      chk("post_rst_id", 64'(last_id), 64'd2);

      // Randomized traffic with random backpressure.
      rdy_mode = 2;
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(0, NUM_REQ - 1);
            if (rq[n].size() < 3)
               push(n, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom(),
                    ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom());
         end
         step();
      end
      drain("random_drain", 3000);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
